// File: rtl/operand_fetch_pkg.sv
// Shared operand-path types: datatype encoding, error bit indices and the
// word unpack function used here and by downstream operand consumers.
package params;

  typedef enum logic [1:0] {
    DT_FP32 = 2'd0,
    DT_FP16 = 2'd1,
    DT_INT8 = 2'd2,
    DT_INT4 = 2'd3
  } dtype_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } opf_state_t;

  // Side information that travels alongside an issued read pair.
  typedef struct packed {
    logic valid;
    logic sub_a;
    logic sub_b;
    logic last;
  } side_t;

  localparam int OPF_DEPTH    = 4;
  localparam int OPF_WIDTH    = 66;
  localparam int ERR_STALL    = 0;
  localparam int ERR_MISMATCH = 1;

  // FP32 passes the word through; narrower types select a 16-bit half.
  function automatic logic [31:0] unpack_word(input logic [31:0] word,
                                              input dtype_t      dt,
                                              input logic        sub);
    logic [15:0] half;
    half = sub ? word[31:16] : word[15:0];
    case (dt)
      DT_FP32: unpack_word = word;
      default: unpack_word = {16'h0000, half};
    endcase
  endfunction

endpackage

// File: rtl/operand_fetch_fifo.sv
// Synchronous operand-pair FIFO; push into a full FIFO is accepted only
// alongside a pop, and the read port shows zero while empty.
module opf_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  // NOTE: storage is not reset; the pointers and count define which entries
  // are live, and rdata is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: issues paired A/B SRAM reads, unpacks the returned words and
// queues operand pairs for the array edge with credit-based upstream stall.
module operand_fetch
  import params::*;
#(
  parameter int SRAM_AW    = 10,
  parameter int FIFO_DEPTH = OPF_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  dtype_t             datatype,
  input  logic               en_A,
  input  logic               cmen_A,
  input  logic [31:0]        rdaddr_A,
  input  logic               en_B,
  input  logic               cmen_B,
  input  logic [31:0]        rdaddr_B,
  output logic               stall,
  output logic               sram_a_re,
  output logic [SRAM_AW-1:0] sram_a_addr,
  input  logic [31:0]        sram_a_rdata,
  output logic               sram_b_re,
  output logic [SRAM_AW-1:0] sram_b_addr,
  input  logic [31:0]        sram_b_rdata,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [31:0]        op_a,
  output logic [31:0]        op_b,
  output logic               op_last,
  output logic               done,
  output logic               busy,
  output logic [1:0]         err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] STALL_AT = (CW+1)'(FIFO_DEPTH - 1);

  opf_state_t           state_q, state_d;
  side_t                s1_q, s1_d, s2_q, s2_d;
  logic [SRAM_AW-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [1:0]           inflight_q, inflight_d, err_q, err_d;
  logic                 done_q, done_d;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full, fifo_empty;
  logic [OPF_WIDTH-1:0] fifo_wdata, fifo_rdata;
  logic                 pair_en, mismatch, want, issue, drain_issue;
  logic                 push, pop, drained;
  logic                 unused_bits;

  // Counts one pair that may already be issued this cycle.
  assign stall = ({1'b0, fifo_count} + (CW+1)'(inflight_q)) >= STALL_AT;

  assign pop  = op_valid && op_ready;
  assign push = s2_q.valid;

  assign fifo_wdata = {1'b0, s2_q.last,
                       unpack_word(sram_a_rdata, datatype, s2_q.sub_a),
                       unpack_word(sram_b_rdata, datatype, s2_q.sub_b)};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    pair_en     = en_A && en_B;
    mismatch    = (en_A != en_B) || (cmen_A != cmen_B);
    want        = pair_en && !mismatch && !stall;
    drain_issue = want && (state_q == ST_DRAIN);
    issue       = want && (state_q != ST_DRAIN);

    s1_d.valid = issue;
    s1_d.sub_a = rdaddr_A[0];
    s1_d.sub_b = rdaddr_B[0];
    s1_d.last  = cmen_A;
    s2_d       = s1_q;
    a_addr_d   = issue ? rdaddr_A[SRAM_AW:1] : a_addr_q;
    b_addr_d   = issue ? rdaddr_B[SRAM_AW:1] : b_addr_q;
    inflight_d = inflight_q + 2'(issue) - 2'(push);

    err_d = err_q;
    if (pair_en && stall)        err_d[ERR_STALL]    = 1'b1;
    if (mismatch || drain_issue) err_d[ERR_MISMATCH] = 1'b1;

    // Empty after this edge: nothing in flight and the last entry leaving.
    drained = (inflight_d == 2'd0) && !push &&
              ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE:  if (issue) state_d = cmen_A ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (issue && cmen_A) state_d = ST_DRAIN;
      ST_DRAIN: if (drained) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s1_q       <= '0;
      s2_q       <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      inflight_q <= '0;
      err_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  opf_fifo #(
    .WIDTH (OPF_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign sram_a_re   = s1_q.valid;
  assign sram_b_re   = s1_q.valid;
  assign sram_a_addr = a_addr_q;
  assign sram_b_addr = b_addr_q;
  assign op_valid    = !fifo_empty;
  assign op_a        = fifo_rdata[63:32];
  assign op_b        = fifo_rdata[31:0];
  assign op_last     = fifo_rdata[64];
  assign done        = done_q;
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;

  assign unused_bits = ^{fifo_full, fifo_rdata[OPF_WIDTH-1],
                         rdaddr_A[31:SRAM_AW+1], rdaddr_B[31:SRAM_AW+1]};

endmodule
